// File: rtl/niios_qsys_nios2_oci_dct_pkg.sv
// Shared types and constants for the OCI DCT packing scheduler.
// State encoding, requester ids and buffer geometry.
package niios_qsys_nios2_oci_dct_pkg;

    localparam int CODE_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = CODE_W * SLOTS;
    localparam int CNT_W  = 4;
    localparam int TMR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } dct_state_e;

    typedef enum logic {
        REQ_ITR = 1'b0,
        REQ_DTR = 1'b1
    } req_id_e;

endpackage

// File: rtl/niios_qsys_nios2_oci_dct_rr_arb.sv
// Two-way round-robin grant between itr (bit 0) and dtr (bit 1).
// The pointer always moves to the requester that was not just served.
module niios_qsys_nios2_oci_dct_rr_arb
    import niios_qsys_nios2_oci_dct_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_e ptr_q;
    req_id_e ptr_d;

    // Lone requester wins; on a tie the pointer decides
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (ptr_q == REQ_DTR) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Flip the pointer away from whoever was granted
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = REQ_DTR;
        end else if (gnt_o[1]) begin
            ptr_d = REQ_ITR;
        end
    end

    // Pointer register, starts on itr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= REQ_ITR;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/niios_qsys_nios2_oci_dct_sched.sv
// OCI DCT packing scheduler: arbitrates trace codes, packs them, emits buffers.
// Optional stall counter output enabled by NIIOS_DCT_STALL_CNT_EN.
module niios_qsys_nios2_oci_dct_sched
    import niios_qsys_nios2_oci_dct_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             itr_valid,
    input  logic [CODE_W-1:0] itr_code,
    output logic             itr_ready,
    input  logic             dtr_valid,
    input  logic [CODE_W-1:0] dtr_code,
    output logic             dtr_ready,
    input  logic             flush_req,
    input  logic             test_ending,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             dct_valid,
    input  logic             dct_ready,
    output logic             test_has_ended
`ifdef NIIOS_DCT_STALL_CNT_EN
    ,
    output logic [15:0]      dct_stall_cnt
`endif
);

    dct_state_e        state_q;
    dct_state_e        state_d;
    logic [BUF_W-1:0]  buf_q;
    logic [BUF_W-1:0]  buf_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  tmr_d;
    logic              end_q;
    logic              end_d;

    logic              acc_en;
    logic [1:0]        gnt;
    logic              acc;
    logic [CODE_W-1:0] code;
    logic              tmo_hit;
    logic              flush;

    assign acc_en = (state_q == ST_IDLE) || (state_q == ST_FILL);

    niios_qsys_nios2_oci_dct_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (acc_en),
        .req_i   ({dtr_valid, itr_valid}),
        .gnt_o   (gnt)
    );

    assign acc  = |gnt;
    assign code = gnt[1] ? dtr_code : itr_code;

    // Pack the granted code into the next free slot; clear on handshake
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (acc) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    buf_d[k*CODE_W +: CODE_W] = code;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_EMIT) && dct_ready) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    // Idle timer counts FILL cycles without an accept, saturating
    always_comb begin
        tmr_d = tmr_q;
        if (acc || (state_q != ST_FILL)) begin
            tmr_d = '0;
        end else if (tmr_q != {TMR_W{1'b1}}) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    assign end_d   = end_q | test_ending;
    assign tmo_hit = !acc && (tmr_q == TMR_W'(TIMEOUT - 1));
    assign flush   = (cnt_d != '0) &&
                     ((cnt_d == CNT_W'(SLOTS)) || flush_req ||
                      tmo_hit || test_ending);

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            cnt_q <= '0;
            tmr_q <= '0;
            end_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            tmr_q <= tmr_d;
            end_q <= end_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (flush) begin
                    state_d = ST_EMIT;
                end else if (cnt_d != '0) begin
                    state_d = ST_FILL;
                end else if (test_ending) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (dct_ready) begin
                    state_d = end_d ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        itr_ready      = gnt[0];
        dtr_ready      = gnt[1];
        dct_valid      = (state_q == ST_EMIT);
        test_has_ended = (state_q == ST_DONE);
        dct_buffer     = buf_q;
        dct_count      = cnt_q;
    end

`ifdef NIIOS_DCT_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    // Count offered-but-not-granted cycles, saturating
    always_comb begin
        stall_d = stall_q;
        if ((itr_valid || dtr_valid) && !acc && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign dct_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_niios_qsys_nios2_oci_dct_sched.sv
// Self-checking bench for the DCT packing scheduler.
// Expected buffers are queued on accept and compared on each handshake.
module tb_niios_qsys_nios2_oci_dct_sched;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        itr_valid = 1'b0;
    logic [1:0]  itr_code = 2'b00;
    logic        itr_ready;
    logic        dtr_valid = 1'b0;
    logic [1:0]  dtr_code = 2'b00;
    logic        dtr_ready;
    logic        flush_req = 1'b0;
    logic        test_ending = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready = 1'b0;
    logic        test_has_ended;
`ifdef NIIOS_DCT_STALL_CNT_EN
    logic [15:0] dct_stall_cnt;
`endif

    niios_qsys_nios2_oci_dct_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .itr_valid      (itr_valid),
        .itr_code       (itr_code),
        .itr_ready      (itr_ready),
        .dtr_valid      (dtr_valid),
        .dtr_code       (dtr_code),
        .dtr_ready      (dtr_ready),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_has_ended (test_has_ended)
`ifdef NIIOS_DCT_STALL_CNT_EN
        ,
        .dct_stall_cnt  (dct_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  cnt;
        logic [29:0] data;
    } pkt_t;

    pkt_t        sb[$];
    pkt_t        mon_p;
    logic        rr_dtr = 1'b0;
    logic [29:0] m_buf = '0;
    int          m_cnt = 0;
    logic [29:0] snap;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Compare each handshaken buffer against the oldest expectation
    always @(negedge clk) begin
        if (reset_n && dct_valid && dct_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_emit", 32'(dct_count), 32'd0);
            end else begin
                mon_p = sb.pop_front();
                chk("emit_count", 32'(dct_count), 32'(mon_p.cnt));
                chk("emit_buffer", 32'(dct_buffer), 32'(mon_p.data));
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        itr_valid = 1'b0;
        dtr_valid = 1'b0;
        flush_req = 1'b0;
        test_ending = 1'b0;
        dct_ready = 1'b0;
        m_cnt = 0;
        m_buf = '0;
        rr_dtr = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Offer one cycle of requests; predict grant and update model buffer
    task automatic offer(input logic iv, input logic [1:0] ic,
                         input logic dv, input logic [1:0] dc);
        logic gi;
        logic gd;
        itr_valid = iv;
        itr_code = ic;
        dtr_valid = dv;
        dtr_code = dc;
        gi = iv && (!dv || !rr_dtr);
        gd = dv && (!iv || rr_dtr);
        @(negedge clk);
        chk("itr_ready", 32'(itr_ready), 32'(gi));
        chk("dtr_ready", 32'(dtr_ready), 32'(gd));
        if (gi || gd) begin
            m_buf[m_cnt*2 +: 2] = gi ? ic : dc;
            m_cnt++;
            rr_dtr = gi;
        end
        @(posedge clk);
        #1;
        itr_valid = 1'b0;
        dtr_valid = 1'b0;
    endtask

    task automatic push_pkt();
        pkt_t p;
        p.cnt = 4'(m_cnt);
        p.data = m_buf;
        sb.push_back(p);
        m_cnt = 0;
        m_buf = '0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(dct_valid), 32'd0);
        chk("rst_count", 32'(dct_count), 32'd0);
        chk("rst_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_ended", 32'(test_has_ended), 32'd0);
        chk("rst_itr_ready", 32'(itr_ready), 32'd0);
        do_reset();

        // Full buffer from itr only, codes k mod 4
        dct_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            offer(1'b1, 2'(i % 4), 1'b0, 2'b00);
        end
        push_pkt();
        wait_drain(10);
        chk("full_pattern_const", 32'(snap_full()), 32'h24E4E4E4);
        @(negedge clk);
        chk("full_back_idle", 32'(dct_valid), 32'd0);
        @(posedge clk);
        #1;

        // Both requesters every cycle: strict alternation
        do_reset();
        dct_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer(1'b1, 2'd1, 1'b1, 2'd2);
        end
        chk("alt_slot0", 32'(m_buf[1:0]), 32'd1);
        chk("alt_slot1", 32'(m_buf[3:2]), 32'd2);
        push_pkt();
        pulse_flush();
        wait_drain(10);

        // Flush of 3 codes with back-pressure
        dct_ready = 1'b0;
        offer(1'b0, 2'b00, 1'b1, 2'd3);
        offer(1'b1, 2'd2, 1'b0, 2'b00);
        offer(1'b1, 2'd1, 1'b1, 2'd0);
        snap = m_buf;
        pulse_flush();
        @(negedge clk);
        chk("flush_valid", 32'(dct_valid), 32'd1);
        chk("flush_count", 32'(dct_count), 32'd3);
        itr_valid = 1'b1;
        dtr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(dct_valid), 32'd1);
            chk("hold_count", 32'(dct_count), 32'd3);
            chk("hold_buffer", 32'(dct_buffer), 32'(snap));
            chk("hold_readies", 32'({itr_ready, dtr_ready}), 32'd0);
        end
        @(posedge clk);
        #1;
        itr_valid = 1'b0;
        dtr_valid = 1'b0;
        push_pkt();
        dct_ready = 1'b1;
        wait_drain(10);

        // Idle timeout with 2 codes
        dct_ready = 1'b0;
        offer(1'b1, 2'd3, 1'b0, 2'b00);
        offer(1'b1, 2'd1, 1'b0, 2'b00);
        k = 0;
        @(negedge clk);
        while (!dct_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_latency", 32'(k), 32'(TIMEOUT));
        chk("tmo_count", 32'(dct_count), 32'd2);
        push_pkt();
        dct_ready = 1'b1;
        wait_drain(10);

        // End-of-test drain of 5 codes
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 2'(3 - (i % 4)), 1'b0, 2'b00);
        end
        push_pkt();
        test_ending = 1'b1;
        wait_drain(10);
        repeat (2) @(posedge clk);
        #1 test_ending = 1'b0;
        itr_valid = 1'b1;
        dtr_valid = 1'b1;
        @(negedge clk);
        chk("end_has_ended", 32'(test_has_ended), 32'd1);
        chk("end_readies", 32'({itr_ready, dtr_ready}), 32'd0);
        chk("end_valid", 32'(dct_valid), 32'd0);
        @(posedge clk);
        #1;

        // test_ending from IDLE
        do_reset();
        test_ending = 1'b1;
        @(negedge clk);
        chk("idle_end_before", 32'(test_has_ended), 32'd0);
        @(negedge clk);
        chk("idle_end_after", 32'(test_has_ended), 32'd1);
        @(posedge clk);
        #1;

        // Reset asserted while emitting
        do_reset();
        offer(1'b1, 2'd2, 1'b0, 2'b00);
        offer(1'b1, 2'd3, 1'b0, 2'b00);
        pulse_flush();
        @(negedge clk);
        chk("mid_emit_valid", 32'(dct_valid), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_emit_valid", 32'(dct_valid), 32'd0);
        chk("rst_emit_count", 32'(dct_count), 32'd0);
        chk("rst_emit_buffer", 32'(dct_buffer), 32'd0);
        do_reset();
        offer(1'b1, 2'd1, 1'b0, 2'b00);
        push_pkt();
        dct_ready = 1'b1;
        pulse_flush();
        wait_drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Independent reference for the k mod 4 full-buffer pattern
    function automatic logic [29:0] snap_full();
        logic [29:0] v;
        v = '0;
        for (int i = 0; i < 15; i++) begin
            v[i*2 +: 2] = 2'(i % 4);
        end
        return v;
    endfunction

endmodule
